// File: rtl/fade_sched_pkg.sv
// Shared types and default constants for the LED fade scheduler.
// The state encoding lives here so the scheduler and any future status logic agree on it.
package fade_sched_pkg;

    localparam int DUTY_W  = 4;
    localparam int TIMER_W = 10;

    localparam int NCH_DEF         = 4;
    localparam int DUTY_MAX_DEF    = 10;
    localparam int STEP_CYCLES_DEF = 70;
    localparam int HOLD_CYCLES_DEF = 320;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UP   = 3'd1,
        ST_HOLD = 3'd2,
        ST_DOWN = 3'd3,
        ST_NEXT = 3'd4
    } state_e;

    function automatic logic [TIMER_W-1:0] to_timer(input int cycles);
        return TIMER_W'(cycles);
    endfunction

endpackage

// File: rtl/fade_tick.sv
// Reloadable down-counter: tick is high for one cycle every `load` cycles.
// The last loaded interval is remembered so the counter re-arms itself on each tick.
module fade_tick
    import fade_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [TIMER_W-1:0] load,
    output logic               tick
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic [TIMER_W-1:0] reload_q, reload_d;

    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        if (load_en) begin
            cnt_d    = load;
            reload_d = load;
        end else if (cnt_q == TIMER_W'(1)) begin
            cnt_d = reload_q;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end

    // A cleared counter (after reset) stays silent until the first load.
    assign tick = (cnt_q == TIMER_W'(1));

endmodule

// File: rtl/fade_sched.sv
// LED fade sequencer: ramps channel duty up, holds, ramps down, either one channel
// at a time (chase) or all together, with an inline PWM comparator per channel.
//   state | meaning
//   IDLE  | waiting for a start edge, all duty 0
//   UP    | target duty +1 per step tick until DUTY_MAX
//   HOLD  | target held at DUTY_MAX for one hold interval
//   DOWN  | target duty -1 per step tick until 0
//   NEXT  | one cycle: advance channel, loop, or finish
module fade_sched
    import fade_sched_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int DUTY_MAX    = DUTY_MAX_DEF,
    parameter int STEP_CYCLES = STEP_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             sync_all,
    input  logic             loop,
    output logic             busy,
    output logic             done,
    output logic [1:0]       ch_idx,
    output logic [4*NCH-1:0] duty,
    output logic [NCH-1:0]   pwm
);

    localparam logic [DUTY_W-1:0]  DMAX    = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0]  DMAX_M1 = DUTY_W'(DUTY_MAX - 1);
    localparam logic [1:0]         CH_LAST = 2'(NCH - 1);
    localparam logic [TIMER_W-1:0] STEP_L  = to_timer(STEP_CYCLES);
    localparam logic [TIMER_W-1:0] HOLD_L  = to_timer(HOLD_CYCLES);

    state_e                       state_q, state_d;
    logic                         start_r_q;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         sync_q, sync_d;
    logic [1:0]                   ch_q, ch_d;
    logic [DUTY_W-1:0]            level_q, level_d;
    logic [NCH-1:0][DUTY_W-1:0]   duty_q, duty_d;
    logic [DUTY_W-1:0]            phase_q, phase_d;
    logic [NCH-1:0]               pwm_q, pwm_d;

    logic                         start_edge;
    logic                         tick;
    logic                         load_en;
    logic [TIMER_W-1:0]           load_val;

    assign start_edge = start & ~start_r_q;

    fade_tick u_tick (
        .clk     (clk),
        .rst     (rst),
        .load_en (load_en),
        .load    (load_val),
        .tick    (tick)
    );

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sync_d   = sync_q;
        ch_d     = ch_q;
        level_d  = level_q;
        load_en  = 1'b0;
        load_val = STEP_L;

        if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            ch_d    = 2'd0;
            level_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // stop wins over a start edge arriving in the same cycle
                    if (start_edge && !stop) begin
                        state_d = ST_UP;
                        busy_d  = 1'b1;
                        ch_d    = 2'd0;
                        sync_d  = sync_all;
                        level_d = '0;
                        load_en = 1'b1;
                    end
                end
                ST_UP: begin
                    if (tick) begin
                        if (level_q >= DMAX_M1) begin
                            level_d  = DMAX;
                            state_d  = ST_HOLD;
                            load_en  = 1'b1;
                            load_val = HOLD_L;
                        end else begin
                            level_d = level_q + DUTY_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state_d = ST_DOWN;
                        load_en = 1'b1;
                    end
                end
                ST_DOWN: begin
                    if (tick) begin
                        if (level_q <= DUTY_W'(1)) begin
                            level_d = '0;
                            state_d = ST_NEXT;
                        end else begin
                            level_d = level_q - DUTY_W'(1);
                        end
                    end
                end
                ST_NEXT: begin
                    if (!sync_q && (ch_q < CH_LAST)) begin
                        ch_d    = ch_q + 2'd1;
                        state_d = ST_UP;
                        load_en = 1'b1;
                    end else if (loop) begin
                        ch_d    = 2'd0;
                        state_d = ST_UP;
                        load_en = 1'b1;
                    end else begin
                        ch_d    = 2'd0;
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ch_d    = 2'd0;
                    level_d = '0;
                end
            endcase
        end

        // One shared level drives whichever channels are currently targeted.
        duty_d = '0;
        for (int i = 0; i < NCH; i++) begin
            duty_d[i] = (sync_d || (ch_d == 2'(i))) ? level_d : '0;
        end

        phase_d = (phase_q >= DMAX_M1) ? '0 : phase_q + DUTY_W'(1);

        pwm_d = '0;
        for (int i = 0; i < NCH; i++) begin
            pwm_d[i] = (duty_q[i] > phase_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            start_r_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sync_q    <= 1'b0;
            ch_q      <= 2'd0;
            level_q   <= '0;
            duty_q    <= '0;
            phase_q   <= '0;
            pwm_q     <= '0;
        end else begin
            state_q   <= state_d;
            start_r_q <= start;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sync_q    <= sync_d;
            ch_q      <= ch_d;
            level_q   <= level_d;
            duty_q    <= duty_d;
            phase_q   <= phase_d;
            pwm_q     <= pwm_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ch_idx = ch_q;
    assign duty   = duty_q;
    assign pwm    = pwm_q;

endmodule

// File: tb/tb_fade_sched.sv
// Bench for fade_sched: directed scenarios plus randomized control traffic, checked every
// cycle against a timeline model (duty as a function of cycles since launch).
module tb_fade_sched;

    localparam int NCH = 2;
    localparam int DM  = 3;
    localparam int SC  = 4;
    localparam int HC  = 8;
    localparam int P   = 2*DM*SC + HC + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, stop = 1'b0, sync_all = 1'b0, loop = 1'b0;
    logic busy, done;
    logic [1:0] ch_idx;
    logic [4*NCH-1:0] duty;
    logic [NCH-1:0] pwm;

    fade_sched #(
        .NCH(NCH), .DUTY_MAX(DM), .STEP_CYCLES(SC), .HOLD_CYCLES(HC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .sync_all(sync_all),
        .loop(loop), .busy(busy), .done(done), .ch_idx(ch_idx), .duty(duty), .pwm(pwm)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit m_act, m_sync, m_done, m_start_prev;
    int m_k, m_phase;
    logic [4*NCH-1:0] e_duty;
    logic [NCH-1:0]   e_pwm;
    int done_seen;

    function automatic int lvl(input int t);
        int u;
        u = DM*SC + HC;
        if (t < DM*SC)              return t / SC;
        else if (t < u)             return DM;
        else if (t < u + DM*SC)     return DM - (t - u) / SC;
        else                        return 0;
    endfunction

    function automatic int e_ch();
        if (m_act && !m_sync) return (m_k % (P*NCH)) / P;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_done = 0; m_start_prev = 0; m_phase = 0; m_k = 0; m_sync = 0;
        e_pwm = '0; e_duty = '0;
    endtask

    task automatic recompute();
        int c, lv;
        c = e_ch();
        for (int i = 0; i < NCH; i++) begin
            lv = (m_act && (m_sync || c == i)) ? lvl(m_k % P) : 0;
            e_duty[4*i +: 4] = 4'(lv);
        end
    endtask

    task automatic check_all();
        chk("busy", 32'(busy), 32'(m_act));
        chk("done", 32'(done), 32'(m_done));
        chk("ch_idx", 32'(ch_idx), 32'(e_ch()));
        chk("duty", 32'(duty), 32'(e_duty));
        chk("pwm", 32'(pwm), 32'(e_pwm));
        if (done === 1'b1) done_seen++;
    endtask

    // Advance one clock: update the model from the inputs present at the edge, then compare.
    task automatic step();
        int pp;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NCH; i++) e_pwm[i] = (e_duty[4*i +: 4] > 4'(m_phase));
            m_phase = (m_phase + 1) % DM;
            m_done = 0;
            pp = m_sync ? P : P*NCH;
            if (m_act && stop) begin
                m_act = 0;
            end else if (m_act) begin
                if ((m_k % pp) == pp - 1 && !loop) begin
                    m_act = 0; m_done = 1;
                end else begin
                    m_k++;
                end
            end else if (start && !m_start_prev && !stop) begin
                m_act = 1; m_k = 0; m_sync = sync_all;
            end
            m_start_prev = start;
        end
        @(posedge clk); #1;
        recompute();
        check_all();
    endtask

    task automatic run_idle(input int maxc);
        for (int n = 0; n < maxc; n++) begin
            if (!m_act) break;
            step();
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int n, dn, pw1, pw3, chg;
        logic [1:0] prev;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_all();
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();

        // chase, loop=0, start held high for 100 cycles
        sync_all = 0; loop = 0; done_seen = 0;
        start = 1; step();
        n = 0;
        while (n < 200 && done !== 1'b1) begin step(); n++; end
        chk("chase_done_at", 32'(n), 32'd66);
        while (n < 99) begin step(); n++; end
        start = 0;
        repeat (3) step();
        chk("chase_done_cnt", 32'(done_seen), 32'd1);

        // sync_all, start edges while busy, PWM duty windows
        sync_all = 1; done_seen = 0; dn = 0; pw1 = 0; pw3 = 0;
        start = 1; step(); start = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 8) start = 1;
            if (k == 9) start = 0;
            if (k == 20) start = 1;
            step();
            if (k >= 5 && k <= 7)   pw1 += int'(pwm[0]);
            if (k >= 14 && k <= 16) pw3 += int'(pwm[1]);
            if (done === 1'b1 && dn == 0) dn = k;
        end
        start = 0; step();
        chk("sync_done_at", 32'(dn), 32'd33);
        chk("sync_done_cnt", 32'(done_seen), 32'd1);
        chk("pwm_duty1_highs", 32'(pw1), 32'd1);
        chk("pwm_duty3_highs", 32'(pw3), 32'd3);

        // chase with loop for two passes, then drop loop
        sync_all = 0; loop = 1; done_seen = 0; chg = 0;
        start = 1; step(); start = 0;
        prev = ch_idx;
        repeat (132) begin
            step();
            if (busy === 1'b1 && ch_idx !== prev) chg++;
            prev = ch_idx;
        end
        chk("loop_no_done", 32'(done_seen), 32'd0);
        chk("loop_ch_changes", 32'(chg), 32'd4);
        loop = 0;
        for (int k = 0; k < 200 && m_act; k++) begin
            step();
            if (busy === 1'b1 && ch_idx !== prev) chg++;
            prev = ch_idx;
        end
        chk("loop_ch_changes_total", 32'(chg), 32'd5);
        chk("loop_done_cnt", 32'(done_seen), 32'd1);

        // stop during HOLD of channel 1, then clean restart
        done_seen = 0;
        start = 1; step(); start = 0;
        repeat (P + 14) step();
        chk("stop_in_hold_ch1", 32'(ch_idx), 32'd1);
        stop = 1; step(); stop = 0;
        chk("stop_busy", 32'(busy), 32'd0);
        repeat (3) step();
        chk("stop_no_done", 32'(done_seen), 32'd0);
        start = 1; step(); start = 0;
        chk("restart_ch", 32'(ch_idx), 32'd0);
        run_idle(200);

        // stop beats a simultaneous start edge in IDLE
        stop = 1; start = 1; step();
        chk("stop_prio_busy", 32'(busy), 32'd0);
        stop = 0; start = 0; step();

        // async reset mid-DOWN
        sync_all = 1;
        start = 1; step(); start = 0;
        repeat (26) step();
        rst = 1'b1; #1;
        model_reset();
        check_all();
        repeat (2) step();
        rst = 1'b0;
        repeat (4) step();
        chk("post_rst_idle", 32'(busy), 32'd0);

        // randomized control traffic
        for (int it = 0; it < 12; it++) begin
            sync_all = 1'($urandom % 2);
            loop = ($urandom % 3) == 0;
            start = 1; step(); start = 0;
            for (int c = 0; c < 400 && m_act; c++) begin
                if ($urandom % 16 == 0) start = ~start;
                if ($urandom % 8 == 0)  loop = ($urandom % 4) == 0;
                if ($urandom % 32 == 0) sync_all = ~sync_all;
                stop = ($urandom % 150) == 0;
                step();
            end
            stop = 0; loop = 0; start = 0;
            step();
            run_idle(300);
            repeat ($urandom % 5 + 1) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fade_sched.md
FADE_SCHED -- requirements
Module: fade_sched

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- NCH, 4, number of LED channels.
- DUTY_MAX, 10, peak duty level; legal range 1..15.
- STEP_CYCLES, 70, clk cycles per duty step; legal range 1..1023.
- HOLD_CYCLES, 320, clk cycles held at peak; legal range 1..1023.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  level input; a rising edge launches a sequence.
- stop  in  1  synchronous abort.
- sync_all  in  1  sampled at launch; 1 = all channels fade together, 0 = channel chase.
- loop  in  1  sampled at end of each pass; 1 = restart the pass.
- busy  out  1  a sequence is active.
- done  out  1  one-cycle pulse when a sequence ends normally.
- ch_idx  out  2  active channel in chase mode.
- duty  out  4*NCH  per-channel duty level; channel i occupies bits [4i+3:4i].
- pwm  out  NCH  per-channel PWM outputs.

Function
REQ-003 A start edge SHALL be detected as start=1 while the registered copy start_r=0; the one-cycle registration delay is inherent to this detection.
REQ-004 States SHALL be IDLE, UP, HOLD, DOWN and NEXT.
REQ-005 In IDLE, a start edge SHALL cause: busy=1, ch_idx=0, sync_all latched, tick timer loaded with STEP_CYCLES, state UP, all on the next clk.
REQ-006 Start edges while busy=1 SHALL be ignored.
REQ-007 The tick timer SHALL pulse exactly once per load interval, i.e. after STEP_CYCLES or HOLD_CYCLES clk cycles; it reloads on every pulse and on every state entry.
REQ-008 UP: each tick SHALL increment the target duty; the tick that brings it to DUTY_MAX SHALL move the FSM to HOLD and load HOLD_CYCLES.
REQ-009 HOLD: the tick SHALL move the FSM to DOWN and load STEP_CYCLES.
REQ-010 DOWN: each tick SHALL decrement the target duty; the tick that reaches 0 SHALL move the FSM to NEXT.
REQ-011 NEXT lasts 1 cycle and SHALL resolve as follows:
- Chase mode with ch_idx<NCH-1: ch_idx+1, then UP.
- Otherwise, loop=1: ch_idx=0, then UP.
- Otherwise, loop=0: IDLE, busy=0, done=1 for one cycle.
REQ-012 Target duty SHALL be duty[ch_idx] in chase mode and all channels in sync_all mode; non-target channels SHALL hold 0.
REQ-013 Duty SHALL never exceed DUTY_MAX nor wrap below 0; no arithmetic wrap is permitted.
REQ-014 stop=1 in any non-IDLE state SHALL, on the next clk, force all duty=0, busy=0, ch_idx=0 and state IDLE, with no done pulse. stop SHALL have priority over a simultaneous start edge.
REQ-015 PWM phase counter SHALL run free over 0..DUTY_MAX-1 and wrap to 0.
REQ-016 pwm[i] SHALL be registered (duty[i] > phase): duty 0 gives constant low, duty DUTY_MAX gives constant high.
REQ-017 Sequence length per pass SHALL be NCH*(2*DUTY_MAX*STEP_CYCLES+HOLD_CYCLES+1) cycles in chase mode, and 2*DUTY_MAX*STEP_CYCLES+HOLD_CYCLES+1 cycles in sync_all mode.

Reset
REQ-018 While rst=1, the block SHALL hold: state IDLE, busy=0, done=0, ch_idx=0, all duty=0, pwm=0, phase=0, start_r=0, timer cleared.
REQ-019 rst asserted mid-sequence SHALL abort immediately and asynchronously; after release, a fresh start edge is required to launch a new sequence.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding and the default constants (DUTY_W=4, TIMER_W=10).
REQ-021 Tick generation SHALL be a sub-module fade_tick with ports clk, rst, load_en, load[9:0] and tick.
REQ-022 PWM compare logic SHALL remain inline in fade_sched.

Verification
REQ-023 The bench SHALL use NCH=2, DUTY_MAX=3, STEP_CYCLES=4, HOLD_CYCLES=8.
REQ-024 Chase, loop=0 -> duty0 steps 1,2,3 at 4-cycle spacing, holds 3 for 8 cycles, then ramps 2,1,0; channel 1 then repeats the pattern; done pulses once, 66 cycles after busy rises.
REQ-025 sync_all=1, loop=0 -> duty0 and duty1 identical at every cycle; done pulses 33 cycles after busy rises.
REQ-026 loop=1 for two passes -> ch_idx sequence 0,1,0,1; no done pulse until loop is dropped, then exactly one done pulse.
REQ-027 stop asserted during HOLD of channel 1 -> next cycle: duty=0, busy=0, no done pulse; a second start edge restarts cleanly at ch_idx=0.
REQ-028 Start held high for 100 cycles, and a start edge while busy -> exactly one sequence runs; rst pulsed mid-DOWN -> all outputs 0 immediately; duty=3 -> pwm constant high; duty=1 -> pwm high 1 of every 3 cycles.
